// File: rtl/interpolator.sv
// Linear interpolation engine: U(T) = U(T0) + (U(T1)-U(T0))*(T-T0)/(T1-T0) per element, via 2 read ports + 1 write port.
// Latency 4+35*m (interior) / 4+3*m (clamped) cycles; Enable low aborts. Optional macro INTERP_ROUND_EN rounds instead of truncating.
module interpolator #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int M_ADD         = 1,
  parameter int T_ADD         = 2,
  parameter int T0_ADD        = 3,
  parameter int T1_ADD        = 5,
  parameter int U0_ADD        = 5457,
  parameter int U1_ADD        = 5507,
  parameter int U_ADD         = 5257
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Interpolate_Enable,
  output logic                     Interpolate_DONE,
  output logic [ADDRESS_WIDTH-1:0] RAM_ADD_RD1,
  output logic [ADDRESS_WIDTH-1:0] RAM_ADD_RD2,
  input  logic [DATA_WIDTH-1:0]    RAM_DATA_RD1,
  input  logic [DATA_WIDTH-1:0]    RAM_DATA_RD2,
  output logic [ADDRESS_WIDTH-1:0] RAM_ADD_WR,
  output logic [DATA_WIDTH-1:0]    RAM_DATA_WR,
  output logic                     RAM_ENABLE_WR
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] HDR1  = 4'd1;
  localparam logic [3:0] HDR2  = 4'd2;
  localparam logic [3:0] HDR3  = 4'd3;
  localparam logic [3:0] ISSUE = 4'd4;
  localparam logic [3:0] LOAD  = 4'd5;
  localparam logic [3:0] DIV   = 4'd6;
  localparam logic [3:0] WRITE = 4'd7;
  localparam logic [3:0] FIN   = 4'd8;

  logic [3:0]  state;
  logic [5:0]  m_q;
  logic [5:0]  idx;
  logic [15:0] t_q, t0_q, t1_q;
  logic [15:0] u0_q;
  logic        neg_q;
  logic [15:0] div_q;
  logic [15:0] rem_q;
  logic [31:0] quo_q;
  logic [4:0]  cnt_q;

  logic [15:0]        u0_in, u1_in, span, dt;
  logic signed [16:0] diff;
  logic signed [32:0] prod, prod_neg;
  logic [31:0]        prod_mag, dividend;
  logic               low_case, high_case;
  logic [16:0]        rem_sh, rem_sub;
  logic               ge;
  logic [15:0]        rem_nx;
  logic [31:0]        quo_nx;
  logic [15:0]        res_div;
  logic [5:0]         idx_nx;
  logic [15:0]        m_raw;
  logic               unused_hi;

  assign unused_hi = ^{RAM_DATA_RD1[DATA_WIDTH-1:16], RAM_DATA_RD2[DATA_WIDTH-1:16]};

  always_comb begin
    u0_in     = RAM_DATA_RD1[15:0];
    u1_in     = RAM_DATA_RD2[15:0];
    m_raw     = RAM_DATA_RD1[15:0];
    span      = t1_q - t0_q;
    dt        = t_q - t0_q;
    diff      = $signed({1'b0, u1_in}) - $signed({1'b0, u0_in});
    prod      = $signed({{16{diff[16]}}, diff}) * $signed({17'b0, dt});
    prod_neg  = -prod;
    prod_mag  = prod[32] ? prod_neg[31:0] : prod[31:0];
`ifdef INTERP_ROUND_EN
    dividend  = prod_mag + {17'b0, span[15:1]};
`else
    dividend  = prod_mag;
`endif
    low_case  = (t_q <= t0_q) || (t1_q <= t0_q);
    high_case = (t_q >= t1_q);
    // One restoring step: the dividend shifts out of quo_q as quotient bits shift in.
    rem_sh    = {rem_q, quo_q[31]};
    ge        = (rem_sh >= {1'b0, div_q});
    rem_sub   = rem_sh - {1'b0, div_q};
    rem_nx    = ge ? rem_sub[15:0] : rem_sh[15:0];
    quo_nx    = {quo_q[30:0], ge};
    res_div   = neg_q ? (u0_q - quo_nx[15:0]) : (u0_q + quo_nx[15:0]);
    idx_nx    = idx + 6'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state            <= IDLE;
      Interpolate_DONE <= 1'b0;
      RAM_ADD_RD1      <= '0;
      RAM_ADD_RD2      <= '0;
      RAM_ADD_WR       <= '0;
      RAM_DATA_WR      <= '0;
      RAM_ENABLE_WR    <= 1'b0;
      m_q              <= '0;
      idx              <= '0;
      t_q              <= '0;
      t0_q             <= '0;
      t1_q             <= '0;
      u0_q             <= '0;
      neg_q            <= 1'b0;
      div_q            <= '0;
      rem_q            <= '0;
      quo_q            <= '0;
      cnt_q            <= '0;
    end else begin
      RAM_ENABLE_WR <= 1'b0;
      if (state != IDLE && !Interpolate_Enable) begin
        state            <= IDLE;
        Interpolate_DONE <= 1'b0;
      end else begin
        case (state)
          IDLE: if (Interpolate_Enable) begin
            RAM_ADD_RD1 <= ADDRESS_WIDTH'(M_ADD);
            RAM_ADD_RD2 <= ADDRESS_WIDTH'(T_ADD);
            state       <= HDR1;
          end
          HDR1: begin
            RAM_ADD_RD1 <= ADDRESS_WIDTH'(T0_ADD);
            RAM_ADD_RD2 <= ADDRESS_WIDTH'(T1_ADD);
            state       <= HDR2;
          end
          HDR2: begin
            m_q   <= (m_raw > 16'd50) ? 6'd50 : m_raw[5:0];
            t_q   <= RAM_DATA_RD2[15:0];
            state <= HDR3;
          end
          HDR3: begin
            t0_q <= RAM_DATA_RD1[15:0];
            t1_q <= RAM_DATA_RD2[15:0];
            idx  <= '0;
            if (m_q == 6'd0) begin
              state <= FIN;
            end else begin
              RAM_ADD_RD1 <= ADDRESS_WIDTH'(U0_ADD);
              RAM_ADD_RD2 <= ADDRESS_WIDTH'(U1_ADD);
              state       <= ISSUE;
            end
          end
          ISSUE: state <= LOAD;
          LOAD: begin
            u0_q <= u0_in;
            if (low_case || high_case) begin
              RAM_ADD_WR    <= ADDRESS_WIDTH'(U_ADD) + ADDRESS_WIDTH'(idx);
              RAM_DATA_WR   <= DATA_WIDTH'(low_case ? u0_in : u1_in);
              RAM_ENABLE_WR <= 1'b1;
              state         <= WRITE;
            end else begin
              neg_q <= prod[32];
              div_q <= span;
              rem_q <= '0;
              quo_q <= dividend;
              cnt_q <= 5'd31;
              state <= DIV;
            end
          end
          DIV: begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
              RAM_ADD_WR    <= ADDRESS_WIDTH'(U_ADD) + ADDRESS_WIDTH'(idx);
              RAM_DATA_WR   <= DATA_WIDTH'(res_div);
              RAM_ENABLE_WR <= 1'b1;
              state         <= WRITE;
            end
          end
          WRITE: begin
            idx <= idx_nx;
            if (idx_nx == m_q) begin
              state <= FIN;
            end else begin
              RAM_ADD_RD1 <= ADDRESS_WIDTH'(U0_ADD) + ADDRESS_WIDTH'(idx_nx);
              RAM_ADD_RD2 <= ADDRESS_WIDTH'(U1_ADD) + ADDRESS_WIDTH'(idx_nx);
              state       <= ISSUE;
            end
          end
          FIN: Interpolate_DONE <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_interpolator.sv
// Scoreboarded directed bench for interpolator: expected writes queued per run, popped by a write monitor.
module tb_interpolator;

  localparam int U0A = 5457;
  localparam int U1A = 5507;
  localparam int UA  = 5257;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        done;
  logic [12:0] add_rd1, add_rd2, add_wr;
  logic [63:0] data_rd1, data_rd2, data_wr;
  logic        wr_en;

  typedef struct packed {
    logic [12:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [63:0] mem [0:8191];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          wr_count = 0;
  bit          done_seen = 0;

  interpolator dut (
    .CLK(clk), .RST(rst), .Interpolate_Enable(en), .Interpolate_DONE(done),
    .RAM_ADD_RD1(add_rd1), .RAM_ADD_RD2(add_rd2),
    .RAM_DATA_RD1(data_rd1), .RAM_DATA_RD2(data_rd2),
    .RAM_ADD_WR(add_wr), .RAM_DATA_WR(data_wr), .RAM_ENABLE_WR(wr_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    data_rd1 <= mem[add_rd1];
    data_rd2 <= mem[add_rd2];
    if (wr_en) mem[add_wr] <= data_wr;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Write monitor: every pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (done) done_seen = 1;
    if (!rst && wr_en) begin
      wr_t e;
      wr_count++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data %0d expected no write", add_wr, data_wr);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", longint'(add_wr), longint'(e.addr));
        chk("wr_data", longint'(data_wr), longint'(e.data));
      end
    end
  end

  task automatic push(input int i, input int v);
    wr_t e;
    e.addr = 13'(UA + i);
    e.data = 64'(v);
    exp_q.push_back(e);
  endtask

  task automatic hdr(input logic [63:0] m, input logic [63:0] t, input int t0, input int t1);
    mem[1] = m;
    mem[2] = t;
    mem[3] = 64'(t0);
    mem[5] = 64'(t1);
  endtask

  task automatic run(input string nm, input int lat, input int nwr);
    int s;
    int w0;
    bit found;
    found = 0;
    w0 = wr_count;
    done_seen = 0;
    @(negedge clk);
    en = 1'b1;
    s = cyc + 1;
    for (int k = 0; k < lat + 30; k++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        break;
      end
    end
    if (!found) begin
      total++;
      bad++;
      $display("FAIL %s_done_timeout: got no DONE expected DONE at edge %0d", nm, lat);
    end else begin
      chk({nm, "_latency"}, longint'(cyc - s), longint'(lat));
    end
    chk({nm, "_writes"}, longint'(wr_count - w0), longint'(nwr));
    chk({nm, "_queue_left"}, longint'(exp_q.size()), 0);
    @(negedge clk);
    chk({nm, "_done_held"}, longint'(done), 1);
    en = 1'b0;
    @(negedge clk);
    chk({nm, "_done_drop"}, longint'(done), 0);
    @(negedge clk);
  endtask

  task automatic abort_run(input string nm, input bit use_rst);
    int w0;
    w0 = wr_count;
    done_seen = 0;
    hdr(64'd3, 64'd5, 0, 10);
    mem[U0A] = 64'd0;   mem[U1A] = 64'd10;
    mem[U0A+1] = 64'd100; mem[U1A+1] = 64'd200;
    mem[U0A+2] = 64'd200; mem[U1A+2] = 64'd300;
    push(0, 5);
    @(negedge clk);
    en = 1'b1;
    // 50 edges in: element 1 is mid-divide.
    repeat (50) @(negedge clk);
    if (use_rst) begin
      rst = 1'b1;
      en  = 1'b0;
      #2;
      chk({nm, "_rst_wr_en"}, longint'(wr_en), 0);
      chk({nm, "_rst_add_wr"}, longint'(add_wr), 0);
      chk({nm, "_rst_data_wr"}, longint'(data_wr), 0);
      chk({nm, "_rst_add_rd1"}, longint'(add_rd1), 0);
      @(negedge clk);
      rst = 1'b0;
    end else begin
      en = 1'b0;
    end
    repeat (60) @(negedge clk);
    chk({nm, "_writes"}, longint'(wr_count - w0), 1);
    chk({nm, "_done_seen"}, longint'(done_seen), 0);
    chk({nm, "_queue_left"}, longint'(exp_q.size()), 0);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    for (int a = 0; a < 8192; a++) mem[a] = 64'd0;
    #2;
    chk("reset_done", longint'(done), 0);
    chk("reset_wr_en", longint'(wr_en), 0);
    chk("reset_add_rd1", longint'(add_rd1), 0);
    chk("reset_add_rd2", longint'(add_rd2), 0);
    chk("reset_add_wr", longint'(add_wr), 0);
    chk("reset_data_wr", longint'(data_wr), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Two interior elements.
    hdr(64'd2, 64'd5, 0, 10);
    mem[U0A] = 64'd0;   mem[U1A] = 64'd10;
    mem[U0A+1] = 64'd100; mem[U1A+1] = 64'd200;
    push(0, 5); push(1, 150);
    run("interior2", 74, 2);

    // Negative slope, with junk in the upper bits of m and T.
    hdr(64'hABCD_0000_0000_0001, 64'h1234_0000_0000_0003, 0, 10);
    mem[U0A] = 64'd100; mem[U1A] = 64'd0;
    push(0, 70);
    run("neg_slope", 39, 1);

    // 20/3: truncation vs rounding.
    hdr(64'd1, 64'd1, 0, 3);
    mem[U0A] = 64'd0; mem[U1A] = 64'd20;
`ifdef INTERP_ROUND_EN
    push(0, 7);
`else
    push(0, 6);
`endif
    run("round", 39, 1);

    // T beyond T1 clamps to u1.
    hdr(64'd1, 64'd12, 0, 10);
    mem[U0A] = 64'd9; mem[U1A] = 64'd55;
    push(0, 55);
    run("clamp_high", 7, 1);

    // Degenerate span T0=T1 clamps to u0 even though T>T1.
    hdr(64'd1, 64'd7, 4, 4);
    mem[U0A] = 64'd33; mem[U1A] = 64'd44;
    push(0, 33);
    run("clamp_span", 7, 1);

    hdr(64'd0, 64'd5, 0, 10);
    run("m_zero", 4, 0);

    // m=60 limited to 50 clamped elements.
    hdr(64'd60, 64'd0, 0, 10);
    for (int i = 0; i < 50; i++) begin
      mem[U0A+i] = 64'(1000 + i);
      push(i, 1000 + i);
    end
    run("m_clamp50", 154, 50);

    abort_run("abort_en", 1'b0);
    abort_run("abort_rst", 1'b1);

    chk("final_queue_empty", longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
